seq_shift_add_mul: RTL and testbench

//  Parametrised sequential radix-2 shift-add multiplier for the MiniAlu datapath (MUL opcode).

---
 rtl/seq_shift_add_mul_pkg.sv | 8 +
 rtl/seq_mul_datapath.sv | 75 +++++++
 rtl/seq_shift_add_mul.sv | 53 +++++
 tb/tb_seq_shift_add_mul.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_mul_pkg.sv
// seq_shift_add_mul_pkg: shared state encodings for the sequential multiplier
package seq_shift_add_mul_pkg;
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mulState_t;
endpackage

// File: rtl/seq_mul_datapath.sv
// seq_mul_datapath: shift-add datapath with optional sign fix-up (SEQ_MUL_SIGNED_EN)
module seq_mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iLoad,
  input  logic                 iStep,
  input  logic                 iFinish,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 iSigned,
`endif
  input  logic [WIDTH-1:0]     iOperandA,
  input  logic [WIDTH-1:0]     iOperandB,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oOverflow
);
  logic [2*WIDTH-1:0] regA, acc, sum, product;
  logic [WIDTH-1:0] regB, magA, magB;
  logic overflow;
  // one adder: the accumulator plus the shifted multiplicand when the multiplier LSB is set
  always_comb sum = acc + (regB[0] ? regA : '0);
`ifdef SEQ_MUL_SIGNED_EN
  logic signFlag, signedMode;
  // magnitudes in, signed fix-up out; the most negative value's magnitude still fits WIDTH bits
  always_comb begin
    magA = iSigned && iOperandA[WIDTH-1] ? -iOperandA : iOperandA;
    magB = iSigned && iOperandB[WIDTH-1] ? -iOperandB : iOperandB;
    product = signFlag ? -sum : sum;
    overflow = signedMode ? ~(&product[2*WIDTH-1:WIDTH-1] | ~|product[2*WIDTH-1:WIDTH-1])
                          : |product[2*WIDTH-1:WIDTH];
  end
  // sign of the product and the mode are fixed at accept time
  always_ff @(posedge Clock)
    if (Reset) begin
      signFlag <= 1'b0;
      signedMode <= 1'b0;
    end else if (iLoad) begin
      signFlag <= iSigned & (iOperandA[WIDTH-1] ^ iOperandB[WIDTH-1]);
      signedMode <= iSigned;
    end
`else
  // unsigned only: operands pass straight through
  always_comb begin
    magA = iOperandA;
    magB = iOperandB;
    product = sum;
    overflow = |sum[2*WIDTH-1:WIDTH];
  end
`endif
  // operand shift registers and accumulator
  always_ff @(posedge Clock)
    if (Reset) begin
      regA <= '0;
      regB <= '0;
      acc <= '0;
    end else if (iLoad) begin
      regA <= {{WIDTH{1'b0}}, magA};
      regB <= magB;
      acc <= '0;
    end else if (iStep) begin
      acc <= sum;
      regA <= regA << 1;
      regB <= regB >> 1;
    end
  // result and overflow captured together on the final step, held until the next finish
  always_ff @(posedge Clock)
    if (Reset) begin
      oResult <= '0;
      oOverflow <= 1'b0;
    end else if (iFinish) begin
      oResult <= product;
      oOverflow <= overflow;
    end
endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: radix-2 shift-add multiplier, start/busy/done handshake (optional SEQ_MUL_SIGNED_EN)
module seq_shift_add_mul
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iOperandA,
  input  logic [WIDTH-1:0]     iOperandB,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 iSigned,
`endif
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oOverflow
);
  mulState_t state, nextState;
  logic [CNT_W-1:0] count;
  logic accept, finish;
  // state register
  always_ff @(posedge Clock) state <= Reset ? MUL_IDLE : nextState;
  // next state: start is only honoured outside RUN
  always_comb nextState = state == MUL_RUN ? (finish ? MUL_DONE : MUL_RUN) : (iStart ? MUL_RUN : MUL_IDLE);
  // outputs and datapath controls
  always_comb begin
    oBusy = state == MUL_RUN;
    oDone = state == MUL_DONE;
    accept = state != MUL_RUN && iStart;
    finish = oBusy && count == CNT_W'(WIDTH - 1);
  end
  // iteration counter: exactly WIDTH run cycles, no early exit on zero operands
  always_ff @(posedge Clock)
    if (Reset || accept) count <= '0;
    else if (oBusy) count <= count + 1'b1;
  seq_mul_datapath #(.WIDTH(WIDTH)) datapath (
    .Clock(Clock),
    .Reset(Reset),
    .iLoad(accept),
    .iStep(oBusy),
    .iFinish(finish),
`ifdef SEQ_MUL_SIGNED_EN
    .iSigned(iSigned),
`endif
    .iOperandA(iOperandA),
    .iOperandB(iOperandB),
    .oResult(oResult),
    .oOverflow(oOverflow)
  );
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul: randomized and directed checks against a cycle-count product model
module tb_seq_shift_add_mul;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, ovf;
  logic [2*W-1:0] res;
  int checks = 0, errors = 0;
  bit ce = 1'b0;
  int mRem = 0;
  logic mDone = 1'b0, mOv = 1'b0, mPendOv = 1'b0;
  logic [2*W-1:0] mRes = '0, mPend = '0;

  seq_shift_add_mul #(.WIDTH(W), .CNT_W(5)) dut (
    .Clock(clk),
    .Reset(rst),
    .iStart(start),
    .iOperandA(a),
    .iOperandB(b),
`ifdef SEQ_MUL_SIGNED_EN
    .iSigned(sgn),
`endif
    .oBusy(busy),
    .oDone(done),
    .oResult(res),
    .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic longint fullProd(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint px = s ? longint'($signed(x)) : longint'(x);
    longint py = s ? longint'($signed(y)) : longint'(y);
    return px * py;
  endfunction

  function automatic logic isOvf(input longint p, input logic s);
    return s ? (p < -32768 || p > 32767) : (p > 65535);
  endfunction

  // model: a run lasts W cycles after acceptance, then the product appears with a one-cycle done
  always @(posedge clk)
    if (rst) begin
      mRem <= 0;
      mDone <= 1'b0;
      mRes <= '0;
      mOv <= 1'b0;
    end else if (mRem > 0) begin
      mRem <= mRem - 1;
      mDone <= mRem == 1;
      if (mRem == 1) begin
        mRes <= mPend;
        mOv <= mPendOv;
      end
    end else begin
      mDone <= 1'b0;
      if (start) begin
        mRem <= W;
        mPend <= 32'(fullProd(a, b, sgn));
        mPendOv <= isOvf(fullProd(a, b, sgn), sgn);
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (ce) begin
      chk("busy", 32'(busy), 32'(mRem > 0));
      chk("done", 32'(done), 32'(mDone));
      chk("result", res, mRes);
      chk("overflow", 32'(ovf), 32'(mOv));
    end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x;
    b = y;
    sgn = s;
    start = 1'b1;
  endtask

  task automatic waitDone(input int pulseAt, input bit keep, input logic [W-1:0] pa, input logic [W-1:0] pb, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && !keep) start = 1'b0;
      if (n == pulseAt) begin
        start = 1'b1;
        a = pa;
        b = pb;
      end
      if (n == pulseAt + 1 && !keep) start = 1'b0;
    end while (!done && n < 40);
    if (!done) begin
      errors++;
      $display("FAIL timeout actual=no_done expected=done_within_40");
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [31:0] expRes, input logic expOv);
    int n;
    launch(x, y, s);
    waitDone(0, 1'b0, '0, '0, n);
    chk({name, "_latency"}, 32'(n), 32'd17);
    chk({name, "_result"}, res, expRes);
    chk({name, "_ovf"}, 32'(ovf), 32'(expOv));
    chk({name, "_model"}, mRes, expRes);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'hFFFF;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ce = 1'b1;
    chk("reset_result", res, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    directed("t1", 16'd3, 16'd5, 1'b0, 32'h0000000F, 1'b0);
    directed("t2", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold", res, 32'hFFFE0001);
    end
    directed("zero", 16'h0000, 16'h1234, 1'b0, 32'h0, 1'b0);
    launch(16'd7, 16'd9, 1'b0);
    waitDone(5, 1'b0, 16'd2, 16'd2, n);
    chk("t3_latency", 32'(n), 32'd17);
    chk("t3_result", res, 32'h3F);
    launch(16'd9, 16'd9, 1'b0);
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_done", 32'(done), 32'h0);
    chk("t4_result", res, 32'h0);
    chk("t4_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    directed("t4b", 16'd4, 16'd4, 1'b0, 32'h10, 1'b0);
    launch(16'd1, 16'd1, 1'b0);
    waitDone(2, 1'b1, 16'd6, 16'd7, n);
    chk("t5a_result", res, 32'h1);
    waitDone(0, 1'b0, '0, '0, n);
    chk("t5_latency", 32'(n), 32'd17);
    chk("t5_result", res, 32'h2A);
`ifdef SEQ_MUL_SIGNED_EN
    directed("t6a", 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, 1'b0);
    directed("t6b", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
`endif
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef SEQ_MUL_SIGNED_EN
      launch(pick(), pick(), 1'($urandom_range(0, 1)));
`else
      launch(pick(), pick(), 1'b0);
`endif
      waitDone($urandom_range(0, 20), 1'b0, pick(), pick(), n);
      chk("rand_latency", 32'(n), 32'd17);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
endmodule
